aes_key_schedule_seq: RTL and testbench

//  Sequential, multi-mode AES key expander. It supports AES-128, AES-192 and AES-256, selected per job.
//  It generates one 32-bit schedule word per clock, so only one SubWord unit is needed instead of a chain of round_key stages.
//  All round keys are stored in an internal word array. Any round key can be read by index after the done pulse.
//  It sits between the key source and the round datapath. It replaces the unrolled combinational expander.

---
 rtl/aes_pkg.sv | 67 ++++++
 rtl/aes_sbox_word.sv | 36 +++
 rtl/aes_key_schedule_seq.sv | 202 ++++++++++++++++++++
 tb/tb_aes_key_schedule_seq.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, key-length decode and GF(2^8) helpers for the sequential key expander.
package aes_pkg;

   typedef logic [31:0]  word_t;
   typedef logic [127:0] rkey_t;

   typedef enum logic [1:0] {
      KeyLen128 = 2'd0,
      KeyLen192 = 2'd1,
      KeyLen256 = 2'd2,
      KeyLenBad = 2'd3
   } key_len_e;

   // Key length in 32-bit words; zero for the illegal encoding.
   function automatic logic [3:0] key_nk(key_len_e kl);
      case (kl)
         KeyLen128: return 4'd4;
         KeyLen192: return 4'd6;
         KeyLen256: return 4'd8;
         default:   return 4'd0;
      endcase
   endfunction

   function automatic logic [3:0] key_nr(key_len_e kl);
      case (kl)
         KeyLen128: return 4'd10;
         KeyLen192: return 4'd12;
         KeyLen256: return 4'd14;
         default:   return 4'd0;
      endcase
   endfunction

   function automatic int unsigned key_bits(key_len_e kl);
      case (kl)
         KeyLen128: return 128;
         KeyLen192: return 192;
         KeyLen256: return 256;
         default:   return 0;
      endcase
   endfunction

   function automatic logic [7:0] xtime(logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = '0;
      sh  = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) acc = acc ^ sh;
         sh = xtime(sh);
      end
      return acc;
   endfunction

   function automatic word_t inv_mix_column(word_t col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
              gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
              gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
              gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
   endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// SubWord: four parallel combinational AES S-boxes, each computed as the GF(2^8) inverse
// followed by the affine transform.
module aes_sbox_word
   import aes_pkg::*;
(
   input  logic [31:0] data_i,
   output logic [31:0] data_o
);

   function automatic logic [7:0] gf_sq(logic [7:0] x);
      return gf_mul(x, x);
   endfunction

   // x^254 is the multiplicative inverse, and maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] gf_inv(logic [7:0] x);
      logic [7:0] x2, x3, x12, x15, x240;
      x2   = gf_sq(x);
      x3   = gf_mul(x2, x);
      x12  = gf_sq(gf_sq(x3));
      x15  = gf_mul(x12, x3);
      x240 = gf_sq(gf_sq(gf_sq(gf_sq(x15))));
      return gf_mul(gf_mul(x240, x12), x2);
   endfunction

   function automatic logic [7:0] sbox(logic [7:0] x);
      logic [7:0] b;
      b = gf_inv(x);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^
             8'h63;
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_byte
      assign data_o[8*g +: 8] = sbox(data_i[8*g +: 8]);
   end

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key expander: one schedule word per clock into a word array.
// Optional AES_KS_EQINV_EN adds equivalent-inverse (InvMixColumns) round-key reads.
module aes_key_schedule_seq
   import aes_pkg::*;
#(
   parameter int unsigned MAX_KEY_BITS = 256
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic [255:0] key_i,
   input  logic [1:0]   key_len_i,
   input  logic         start_v_i,
   output logic         ready_o,
   output logic         done_o,
   output logic         err_o,
   output logic         keys_valid_o,
   output logic [3:0]   nr_o,
   input  logic [3:0]   rd_round_i,
   input  logic         rd_dec_i,
   output logic [127:0] rd_key_o
);

   localparam int unsigned MaxNk = MAX_KEY_BITS / 32;
   localparam int unsigned MaxNr = MaxNk + 6;
   localparam int unsigned Depth = 4 * (MaxNr + 1);

   typedef enum logic [0:0] {StIdle, StExpand} state_e;

   state_e     state_q, state_d;
   logic [5:0] i_q, i_d;
   logic [5:0] last_q, last_d;
   logic [2:0] j_q, j_d;
   logic [3:0] nk_q, nk_d;
   logic [3:0] nr_q, nr_d;
   logic [7:0] rcon_q, rcon_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic       valid_q, valid_d;

   word_t w_q   [Depth];
   word_t win_q [MaxNk];
   word_t key_w [8];

   key_len_e   key_len;
   logic [3:0] nk_new;
   logic       mode_ok, req, accept;
   word_t      temp, prev, sub_in, sub_out, mixed, new_word;

   for (genvar g = 0; g < 8; g++) begin : g_key_words
      assign key_w[g] = key_i[255 - 32*g -: 32];
   end

   assign key_len = key_len_e'(key_len_i);
   assign nk_new  = key_nk(key_len);
   assign mode_ok = (key_len != KeyLenBad) && (key_bits(key_len) <= MAX_KEY_BITS);
   assign req     = start_v_i && ready_o;
   assign accept  = req && mode_ok;

   // done_q keeps ready low in the done cycle so a new job cannot start alongside it.
   assign ready_o      = (state_q == StIdle) && !done_q;
   assign done_o       = done_q;
   assign err_o        = err_q;
   assign keys_valid_o = valid_q;
   assign nr_o         = nr_q;

   // win_q[0] holds w[i-1]; w[i-Nk] sits at window slot Nk-1.
   always_comb begin
      temp = win_q[0];
      prev = '0;
      for (int k = 0; k < MaxNk; k++) begin
         if (4'(k) == nk_q - 4'd1) prev = win_q[k];
      end
   end

   assign sub_in = (j_q == 3'd0) ? {temp[23:0], temp[31:24]} : temp;

   aes_sbox_word u_sbox (
      .data_i (sub_in),
      .data_o (sub_out)
   );

   always_comb begin
      if (j_q == 3'd0) begin
         mixed = sub_out ^ {rcon_q, 24'h0};
      end else if (nk_q == 4'd8 && j_q == 3'd4) begin
         mixed = sub_out;
      end else begin
         mixed = temp;
      end
   end

   assign new_word = prev ^ mixed;

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      nk_d    = nk_q;
      nr_d    = nr_q;
      last_d  = last_q;
      rcon_d  = rcon_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      err_d   = req && !mode_ok;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               nk_d    = nk_new;
               nr_d    = key_nr(key_len);
               i_d     = {2'b00, nk_new};
               last_d  = {nr_d, 2'b11};
               j_d     = 3'd0;
               rcon_d  = 8'h01;
               valid_d = 1'b0;
               state_d = StExpand;
            end
         end
         StExpand: begin
            i_d = i_q + 6'd1;
            j_d = ({1'b0, j_q} == nk_q - 4'd1) ? 3'd0 : j_q + 3'd1;
            if (j_q == 3'd0) rcon_d = xtime(rcon_q);
            if (i_q == last_q) begin
               state_d = StIdle;
               done_d  = 1'b1;
               valid_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= StIdle;
         i_q     <= '0;
         j_q     <= '0;
         nk_q    <= '0;
         nr_q    <= '0;
         last_q  <= '0;
         rcon_q  <= 8'h01;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         nk_q    <= nk_d;
         nr_q    <= nr_d;
         last_q  <= last_d;
         rcon_q  <= rcon_d;
         done_q  <= done_d;
         err_q   <= err_d;
         valid_q <= valid_d;
      end
   end

   // Storage and window carry no reset; only writes are suppressed while reset is held.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         if (accept) begin
            for (int k = 0; k < MaxNk; k++) begin
               if (4'(k) < nk_new) begin
                  w_q[k]   <= key_w[k];
                  win_q[k] <= key_w[3'(nk_new - 4'd1 - 4'(k))];
               end
            end
         end else if (state_q == StExpand) begin
            w_q[i_q] <= new_word;
            win_q[0] <= new_word;
            for (int k = 1; k < MaxNk; k++) begin
               win_q[k] <= win_q[k-1];
            end
         end
      end
   end

   logic [5:0] rd_base;
   rkey_t      rd_raw, rd_sel;

   assign rd_base = {rd_round_i, 2'b00};
   assign rd_raw  = {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2],
                     w_q[rd_base + 6'd3]};

`ifdef AES_KS_EQINV_EN
   always_comb begin
      if (rd_dec_i && rd_round_i != 4'd0 && rd_round_i < nr_q) begin
         rd_sel = {inv_mix_column(rd_raw[127:96]), inv_mix_column(rd_raw[95:64]),
                   inv_mix_column(rd_raw[63:32]), inv_mix_column(rd_raw[31:0])};
      end else begin
         rd_sel = rd_raw;
      end
   end
`else
   logic unused_rd_dec;
   assign unused_rd_dec = rd_dec_i;
   assign rd_sel        = rd_raw;
`endif

   assign rd_key_o = (rd_round_i > nr_q) ? '0 : rd_sel;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Self-checking bench for aes_key_schedule_seq: known-answer keys, random keys against a
// word-level FIPS-197 model, rejects, busy starts, mid-expansion reset, narrow build.
module tb_aes_key_schedule_seq;

   logic         clk = 1'b0;
   logic         reset_i;
   logic [255:0] key_i;
   logic [1:0]   key_len_i;
   logic         start_v_i;
   logic         ready_o, done_o, err_o, keys_valid_o;
   logic [3:0]   nr_o;
   logic [3:0]   rd_round_i;
   logic         rd_dec_i;
   logic [127:0] rd_key_o;

   logic [255:0] s_key;
   logic [1:0]   s_len;
   logic         s_start;
   logic         s_ready, s_done, s_err, s_valid;
   logic [3:0]   s_nr;
   logic [3:0]   s_round;
   logic         s_dec;
   logic [127:0] s_rkey;

   always #5 clk = ~clk;

   aes_key_schedule_seq #(.MAX_KEY_BITS(256)) dut (
      .clk_i(clk), .reset_i(reset_i), .key_i(key_i), .key_len_i(key_len_i),
      .start_v_i(start_v_i), .ready_o(ready_o), .done_o(done_o), .err_o(err_o),
      .keys_valid_o(keys_valid_o), .nr_o(nr_o), .rd_round_i(rd_round_i),
      .rd_dec_i(rd_dec_i), .rd_key_o(rd_key_o)
   );

   aes_key_schedule_seq #(.MAX_KEY_BITS(128)) dut128 (
      .clk_i(clk), .reset_i(reset_i), .key_i(s_key), .key_len_i(s_len),
      .start_v_i(s_start), .ready_o(s_ready), .done_o(s_done), .err_o(s_err),
      .keys_valid_o(s_valid), .nr_o(s_nr), .rd_round_i(s_round),
      .rd_dec_i(s_dec), .rd_key_o(s_rkey)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0]  sbox_t [256];
   logic [31:0] model_w [60];
   logic [7:0]  rcon_tab [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                  8'h80, 8'h1b, 8'h36};

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // S-box table built by walking the multiplicative group with generator 3.
   task automatic gen_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'h0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sbox_t[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sbox_t[0] = 8'h63;
   endtask

   function automatic logic [31:0] sub_word(logic [31:0] x);
      return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
   endfunction

   task automatic model_expand(input logic [255:0] key, input int nk);
      logic [31:0] t;
      for (int i = 0; i < 4 * (nk + 7); i++) begin
         if (i < nk) begin
            model_w[i] = key[255 - 32*i -: 32];
         end else begin
            t = model_w[i-1];
            if (i % nk == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon_tab[i / nk], 24'h0};
            else if (nk > 6 && i % nk == 4) t = sub_word(t);
            model_w[i] = model_w[i-nk] ^ t;
         end
      end
   endtask

   function automatic logic [127:0] model_round(int r);
      return {model_w[4*r], model_w[4*r+1], model_w[4*r+2], model_w[4*r+3]};
   endfunction

   function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
      logic [7:0] acc = 8'h00;
      logic [7:0] aa = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) acc = acc ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   function automatic logic [31:0] imc(logic [31:0] col);
      logic [7:0] coef [4];
      logic [31:0] res = '0;
      logic [7:0] acc;
      coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      for (int r = 0; r < 4; r++) begin
         acc = 8'h00;
         for (int c = 0; c < 4; c++) acc = acc ^ gm(coef[(c - r + 4) % 4], col[31 - 8*c -: 8]);
         res[31 - 8*r -: 8] = acc;
      end
      return res;
   endfunction

   function automatic logic [127:0] imc_key(logic [127:0] k);
      return {imc(k[127:96]), imc(k[95:64]), imc(k[63:32]), imc(k[31:0])};
   endfunction

   function automatic logic [255:0] rand_key();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic do_job(input string name, input logic [255:0] key, input logic [1:0] len,
                         input bit hold, input bit has_kat, input logic [127:0] kat);
      int nk, nr, lat, exp_lat;
      logic [127:0] enc, exp;
      nk = 4 + 2 * int'(len);
      nr = nk + 6;
      exp_lat = 4 * (nr + 1) - nk + 1;
      model_expand(key, nk);
      @(negedge clk);
      check({name, " ready before start"}, 128'(ready_o), 128'(1));
      key_i = key;
      key_len_i = len;
      start_v_i = 1'b1;
      @(posedge clk);
      #1;
      if (hold) key_i = ~key;
      else start_v_i = 1'b0;
      lat = 0;
      for (int c = 1; c <= 100 && lat == 0; c++) begin
         @(negedge clk);
         if (c == 1) check({name, " busy"}, 128'({ready_o, keys_valid_o}), 128'(0));
         if (done_o) lat = c;
      end
      start_v_i = 1'b0;
      check({name, " done latency"}, 128'(lat), 128'(exp_lat));
      check({name, " ready with done"}, 128'(ready_o), 128'(0));
      check({name, " keys_valid"}, 128'(keys_valid_o), 128'(1));
      check({name, " nr"}, 128'(nr_o), 128'(nr));
      @(negedge clk);
      check({name, " done pulse end"}, 128'({done_o, ready_o}), 128'(1));
      rd_dec_i = 1'b0;
      for (int r = 0; r <= nr; r++) begin
         rd_round_i = 4'(r);
         #1;
         check($sformatf("%s round %0d", name, r), rd_key_o, model_round(r));
         if (has_kat && r == nr) check({name, " known answer"}, rd_key_o, kat);
         @(negedge clk);
      end
      rd_dec_i = 1'b1;
      for (int r = 0; r <= nr; r++) begin
         rd_round_i = 4'(r);
         enc = model_round(r);
`ifdef AES_KS_EQINV_EN
         exp = (r == 0 || r == nr) ? enc : imc_key(enc);
`else
         exp = enc;
`endif
         #1;
         check($sformatf("%s dec round %0d", name, r), rd_key_o, exp);
         @(negedge clk);
      end
      rd_round_i = 4'(nr + 1);
      #1;
      check({name, " beyond nr"}, rd_key_o, 128'h0);
      rd_dec_i = 1'b0;
      rd_round_i = 4'd0;
   endtask

   initial begin
      int errs, dones, lat;
      bit rdy;
      logic [1:0] len;
      gen_sbox();
      reset_i = 1'b1;
      key_i = '0;
      key_len_i = 2'd0;
      start_v_i = 1'b0;
      rd_round_i = 4'd0;
      rd_dec_i = 1'b0;
      s_key = '0;
      s_len = 2'd0;
      s_start = 1'b0;
      s_round = 4'd0;
      s_dec = 1'b0;
      repeat (3) @(negedge clk);
      reset_i = 1'b0;
      @(negedge clk);
      check("reset outputs", 128'({ready_o, done_o, err_o, keys_valid_o, nr_o}), 128'(8'h80));

      do_job("kat128", {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 2'd0, 1'b0, 1'b1,
             128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      do_job("kat192", {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 2'd1,
             1'b0, 1'b1, 128'he98ba06f448c773c8ecc720401002202);
      do_job("kat256", 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
             2'd2, 1'b0, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e);

      // Illegal length: single err pulse, nothing else disturbed.
      @(negedge clk);
      key_i = rand_key();
      key_len_i = 2'd3;
      start_v_i = 1'b1;
      #1;
      errs = int'(err_o);
      rdy = ready_o;
      @(posedge clk);
      #1;
      start_v_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         errs += int'(err_o);
         rdy &= ready_o;
      end
      check("reject err pulses", 128'(errs), 128'(1));
      check("reject ready", 128'(rdy), 128'(1));
      check("reject keys_valid/nr", 128'({keys_valid_o, nr_o}), 128'({1'b1, 4'd14}));
      rd_round_i = 4'd7;
      #1;
      check("reject storage", rd_key_o, model_round(7));
      rd_round_i = 4'd0;

      do_job("hold192", rand_key(), 2'd1, 1'b1, 1'b0, 128'h0);
      for (int n = 0; n < 6; n++) begin
         len = 2'($urandom_range(2, 0));
         do_job($sformatf("rand%0d", n), rand_key(), len, 1'b0, 1'b0, 128'h0);
      end

      // Reset in the middle of an AES-256 expansion.
      @(negedge clk);
      key_i = rand_key();
      key_len_i = 2'd2;
      start_v_i = 1'b1;
      @(posedge clk);
      #1;
      start_v_i = 1'b0;
      repeat (20) @(negedge clk);
      reset_i = 1'b1;
      @(posedge clk);
      #1;
      reset_i = 1'b0;
      @(negedge clk);
      check("mid reset outputs", 128'({ready_o, done_o, keys_valid_o, nr_o}), 128'(7'h40));
      dones = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         dones += int'(done_o);
      end
      check("mid reset no done", 128'(dones), 128'(0));
      do_job("after reset", rand_key(), 2'd0, 1'b0, 1'b0, 128'h0);

      // 128-bit-only build rejects AES-256 but still runs AES-128.
      @(negedge clk);
      s_key = rand_key();
      s_len = 2'd2;
      s_start = 1'b1;
      #1;
      errs = int'(s_err);
      rdy = s_ready;
      @(posedge clk);
      #1;
      s_start = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         errs += int'(s_err);
         rdy &= s_ready;
      end
      check("narrow reject err", 128'(errs), 128'(1));
      check("narrow reject ready/valid", 128'({rdy, s_valid, s_nr}), 128'(6'h20));
      s_key = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
      s_len = 2'd0;
      s_start = 1'b1;
      @(posedge clk);
      #1;
      s_start = 1'b0;
      lat = 0;
      for (int c = 1; c <= 100 && lat == 0; c++) begin
         @(negedge clk);
         if (s_done) lat = c;
      end
      check("narrow latency", 128'(lat), 128'(41));
      check("narrow nr", 128'(s_nr), 128'(10));
      s_round = 4'd10;
      #1;
      check("narrow round 10", s_rkey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
